// File: rtl/sub8_serial_if.sv
// sub8_serial_if: pushbutton, switch and LED bundle of the bit-serial subtractor.
interface sub8_serial_if;
    logic        btnU;
    logic [15:0] sw;
    logic [15:0] led;
    modport master (output btnU, sw, input led);
    modport slave (input btnU, sw, output led);
endinterface

// File: rtl/sub8_serial.sv
// sub8_serial: bit-serial 8-bit subtractor (A=sw[7:0], B=sw[15:8]) started by a synchronised btnU edge.
// Define SUB8_OVF_EN to enable the registered signed-overflow flag on led[11].
module sub8_serial #(
    parameter int SYNC_STAGES = 2
) (
    input logic          clk,
    input logic          rst,
    sub8_serial_if.slave io
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q, fill_q, armed_q;
    logic [7:0]             a_q, b_q, diff_q;
    logic                   br_q;
    logic [3:0]             cnt_q;
    logic                   start, ai, bi, d;
`ifdef SUB8_OVF_EN
    logic                   ovf_q;
`endif

    // armed_q stays low until the button is seen released after reset, so a held button cannot start
    assign start = armed_q & sync_q[SYNC_STAGES-1] & ~prev_q;
    assign ai    = a_q[cnt_q[2:0]];
    assign bi    = b_q[cnt_q[2:0]];
    assign d     = ai ^ bi ^ br_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            fill_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], io.btnU};
            prev_q  <= sync_q[SYNC_STAGES-1];
            fill_q  <= 1'b1;
            armed_q <= armed_q | (fill_q & ~sync_q[0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
`ifdef SUB8_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else if (start && state_q != RUN) begin
            a_q     <= io.sw[7:0];
            b_q     <= io.sw[15:8];
            diff_q  <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= RUN;
`ifdef SUB8_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else if (state_q == RUN) begin
            diff_q <= {d, diff_q[7:1]};
            br_q   <= (~ai & bi) | (~(ai ^ bi) & br_q);
            cnt_q  <= cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
                state_q <= DONE;
`ifdef SUB8_OVF_EN
                ovf_q   <= (a_q[7] ^ b_q[7]) & (a_q[7] ^ d);
`endif
            end
        end
    end

`ifdef SUB8_OVF_EN
    assign io.led = {cnt_q, ovf_q, state_q == DONE, state_q == RUN, br_q, diff_q};
`else
    assign io.led = {cnt_q, 1'b0, state_q == DONE, state_q == RUN, br_q, diff_q};
`endif
endmodule
